rx_collector: RTL

//  Far-end drain of the transmit path. Pops the D0/D1 destination FIFOs and

---
 rtl/rx_collector.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/rx_collector.sv
// rx_collector: drains the D0/D1 destination FIFOs into one registered
// valid/ready output stream with per-source word counters and link status.
// Optional build macro RX_ROUTE_CHECK_EN: checks rx_data[4] of every captured
// word against its source FIFO and flags a mismatch as a link error.
module rx_collector #(
    parameter int unsigned data_width = 6,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [data_width-1:0] data_out_D0,
    input  logic [data_width-1:0] data_out_D1,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic                  error_D0,
    input  logic                  error_D1,
    input  logic                  out_ready,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [data_width-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_src,
    output logic [cnt_width-1:0]  count_D0,
    output logic [cnt_width-1:0]  count_D1,
    output logic                  rx_idle,
    output logic                  rx_error
);

    localparam int unsigned ROUTE_BIT = 4;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  pending;
    logic                  pend_src;
    logic                  last_src;
    logic                  pop_ok_c;
    logic                  sel_d1_c;
    logic                  route_err_c;
    logic [data_width-1:0] cap_data_c;

    // Pop arbitration: round-robin when both FIFOs hold data, else the non-empty one
    always_comb begin
        pop_ok_c   = 1'b0;
        sel_d1_c   = 1'b0;
        D0_pop     = 1'b0;
        D1_pop     = 1'b0;
        cap_data_c = pend_src ? data_out_D1 : data_out_D0;
        pop_ok_c   = ((state == ST_IDLE) || (state == ST_ACTIVE)) && !pending &&
                     (!rx_valid || out_ready) && !init && !reset;
        if (empty_fifo_D0) begin
            sel_d1_c = 1'b1;
        end else if (empty_fifo_D1) begin
            sel_d1_c = 1'b0;
        end else begin
            sel_d1_c = !last_src;
        end
        D0_pop = pop_ok_c && !sel_d1_c && !empty_fifo_D0;
        D1_pop = pop_ok_c &&  sel_d1_c && !empty_fifo_D1;
    end

    // Route check on the word being captured this cycle
    always_comb begin
        route_err_c = 1'b0;
`ifdef RX_ROUTE_CHECK_EN
        route_err_c = pending && (cap_data_c[ROUTE_BIT] != pend_src);
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; init overrides errors, errors override normal flow
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RESET:  if (init) state_nxt = ST_INIT;
            ST_INIT:   if (!init) state_nxt = ST_IDLE;
            ST_IDLE:   if (!empty_fifo_D0 || !empty_fifo_D1) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (empty_fifo_D0 && empty_fifo_D1 && !pending && !rx_valid)
                           state_nxt = ST_IDLE;
            ST_ERROR:  state_nxt = ST_ERROR;
            default:   state_nxt = ST_RESET;
        endcase
        if (state != ST_RESET) begin
            if (error_D0 || error_D1 || route_err_c) state_nxt = ST_ERROR;
            if (init) state_nxt = ST_INIT;
        end
    end

    // Pop-to-capture pipeline, output register, handshake and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= 1'b0;
            pend_src <= 1'b0;
            last_src <= 1'b1;
            rx_data  <= '0;
            rx_src   <= 1'b0;
            rx_valid <= 1'b0;
            count_D0 <= '0;
            count_D1 <= '0;
        end else if (init || (state == ST_INIT)) begin
            pending  <= 1'b0;
            pend_src <= 1'b0;
            last_src <= 1'b1;
            rx_valid <= 1'b0;
            count_D0 <= '0;
            count_D1 <= '0;
        end else begin
            pending <= D0_pop || D1_pop;
            if (D0_pop || D1_pop) begin
                pend_src <= D1_pop;
                last_src <= D1_pop;
            end
            if (pending) begin
                rx_data  <= cap_data_c;
                rx_src   <= pend_src;
                rx_valid <= 1'b1;
                if (pend_src) count_D1 <= count_D1 + cnt_width'(1);
                else          count_D0 <= count_D0 + cnt_width'(1);
            end else if (rx_valid && out_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // Status decoded straight from the state register
    always_comb begin
        rx_idle  = (state == ST_IDLE);
        rx_error = (state == ST_ERROR);
    end

endmodule
